// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: instruction field layout, mode
// encodings and the fetch-unit state type.
package cpu_pkg;

  // Instruction mode encodings (instr[7:6]), also decoded by the controller.
  localparam logic [1:0] MODE_JUMP  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_STORE = 2'b10;
  localparam logic [1:0] MODE_ALU   = 2'b11;

  // Field positions inside an instruction byte.
  localparam int unsigned MODE_MSB = 7;
  localparam int unsigned MODE_LSB = 6;
  localparam int unsigned OP_MSB   = 1;
  localparam int unsigned OP_LSB   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter: a jump target has priority over the sequential increment,
// and the increment wraps modulo 2^ADDR_W.
module pc_reg #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_q;

  // Next PC: redirect beats increment; natural overflow gives the wrap.
  always_comb begin
    pc_next = pc_q;
    if (load) begin
      pc_next = load_pc;
    end else if (inc) begin
      pc_next = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches one byte per req/ack
// transaction and holds it for the consumer over a valid/ready handshake.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr,
  output logic [1:0]        instr_mode,
  output logic [1:0]        instr_opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic              kill_q, kill_d;
  // One-cycle request bubble after a killed response.
  logic              gap_q, gap_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  // Address of the outstanding request; tracks pc except while a killed
  // request is still waiting for its ack.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              req;
  logic              pc_inc;

  assign req    = (state_q == FETCH) && !gap_q;
  assign pc_inc = (state_q == ISSUE) && instr_ready;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (redirect_valid),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc),
    .pc_next(pc_next)
  );

  // Fetch FSM, kill tracking and instruction capture.
  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    gap_d      = 1'b0;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    addr_d     = (req && !imem_ack) ? addr_q : pc_next;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (req && imem_ack) begin
          if (kill_q || redirect_valid) begin
            // Stale response: drop it and refetch from the new pc.
            kill_d = 1'b0;
            gap_d  = 1'b1;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
            state_d    = ISSUE;
          end
        end else if (req && redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      ISSUE: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end else if (instr_ready) begin
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      gap_q      <= 1'b0;
      instr_q    <= 8'h00;
      instr_pc_q <= '0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      gap_q      <= gap_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign imem_req     = req;
  assign imem_addr    = addr_q;
  assign instr_valid  = (state_q == ISSUE);
  assign halted       = (state_q == IDLE);
  assign instr        = instr_q;
  assign instr_mode   = instr_q[MODE_MSB:MODE_LSB];
  assign instr_opcode = instr_q[OP_MSB:OP_LSB];
  assign instr_pc     = instr_pc_q;

  logic unused_pc;
  assign unused_pc = ^pc;

endmodule
